// File: rtl/em_project_final_pd_avmm_cmd_master_pkg.sv
// Shared definitions for the Avalon-MM command master: FSM state encoding,
// Avalon idle strobe levels, default bus widths and the wait-counter width helper.
package em_project_final_pd_avmm_cmd_master_pkg;

    localparam int DEFAULT_ADDR_W = 2;
    localparam int DEFAULT_DATA_W = 32;

    localparam logic AVM_STROBE_IDLE = 1'b1;
    localparam logic AVM_CS_IDLE     = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_RD_WAIT = 2'd2,
        ST_RESP    = 2'd3
    } state_e;

    // A disabled timeout (0) still needs a 1-bit counter so the port widths stay legal.
    function automatic int cnt_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/em_project_final_pd_avmm_cmd_master_wait_timer.sv
// Saturating waitrequest stall counter; flags the stall edge on which a
// transfer has to be abandoned.
module em_project_final_pd_avmm_cmd_master_wait_timer
    import em_project_final_pd_avmm_cmd_master_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int              CNT_W   = cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] wait_cnt_q;
    logic [CNT_W-1:0] wait_cnt_d;

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (clear) begin
            wait_cnt_d = '0;
        end else if (enable && (wait_cnt_q != CNT_MAX)) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Evaluated on a stall edge before the increment, so TIMEOUT stall edges elapse in total.
    assign expired = (TIMEOUT != 0) && (wait_cnt_q == LAST);

endmodule

// File: rtl/em_project_final_pd_avmm_cmd_master.sv
// Avalon-MM initiator executing one single-word read or write at a time, with
// waitrequest stall handling, fixed read latency and a stall timeout.
module em_project_final_pd_avmm_cmd_master
    import em_project_final_pd_avmm_cmd_master_pkg::*;
#(
    parameter int ADDR_W       = DEFAULT_ADDR_W,
    parameter int DATA_W       = DEFAULT_DATA_W,
    parameter int READ_LATENCY = 0,
    parameter int TIMEOUT      = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_address,
    input  logic [DATA_W-1:0] cmd_writedata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_readdata,
    output logic              rsp_error,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_chipselect,
    output logic              avm_write_n,
    output logic              avm_read_n,
    output logic [DATA_W-1:0] avm_writedata,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_waitrequest
);

    localparam logic [1:0] LAT = 2'(READ_LATENCY);

    state_e            state_q, state_d;
    logic              is_write_q, is_write_d;
    logic [1:0]        lat_cnt_q, lat_cnt_d;
    logic [ADDR_W-1:0] avm_address_q, avm_address_d;
    logic              avm_chipselect_q, avm_chipselect_d;
    logic              avm_write_n_q, avm_write_n_d;
    logic              avm_read_n_q, avm_read_n_d;
    logic [DATA_W-1:0] avm_writedata_q, avm_writedata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_readdata_q, rsp_readdata_d;
    logic              rsp_error_q, rsp_error_d;

    logic timer_clear;
    logic timer_enable;
    logic timer_expired;

    em_project_final_pd_avmm_cmd_master_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .expired (timer_expired)
    );

    assign cmd_ready = (state_q == ST_IDLE) && !reset;

    always_comb begin
        state_d          = state_q;
        is_write_d       = is_write_q;
        lat_cnt_d        = lat_cnt_q;
        avm_address_d    = avm_address_q;
        avm_chipselect_d = avm_chipselect_q;
        avm_write_n_d    = avm_write_n_q;
        avm_read_n_d     = avm_read_n_q;
        avm_writedata_d  = avm_writedata_q;
        rsp_valid_d      = rsp_valid_q;
        rsp_readdata_d   = rsp_readdata_q;
        rsp_error_d      = rsp_error_q;
        timer_clear      = 1'b0;
        timer_enable     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    is_write_d       = cmd_write;
                    avm_address_d    = cmd_address;
                    avm_writedata_d  = cmd_writedata;
                    avm_chipselect_d = 1'b1;
                    avm_write_n_d    = !cmd_write;
                    avm_read_n_d     = cmd_write;
                    timer_clear      = 1'b1;
                    state_d          = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                // An accepting edge wins over a timeout landing on the same edge.
                if (!avm_waitrequest) begin
                    avm_chipselect_d = AVM_CS_IDLE;
                    avm_write_n_d    = AVM_STROBE_IDLE;
                    avm_read_n_d     = AVM_STROBE_IDLE;
                    if (is_write_q) begin
                        rsp_valid_d    = 1'b1;
                        rsp_readdata_d = '0;
                        rsp_error_d    = 1'b0;
                        state_d        = ST_RESP;
                    end else if (READ_LATENCY == 0) begin
                        rsp_valid_d    = 1'b1;
                        rsp_readdata_d = avm_readdata;
                        rsp_error_d    = 1'b0;
                        state_d        = ST_RESP;
                    end else begin
                        lat_cnt_d = 2'd1;
                        state_d   = ST_RD_WAIT;
                    end
                end else begin
                    timer_enable = 1'b1;
                    if (timer_expired) begin
                        avm_chipselect_d = AVM_CS_IDLE;
                        avm_write_n_d    = AVM_STROBE_IDLE;
                        avm_read_n_d     = AVM_STROBE_IDLE;
                        rsp_valid_d      = 1'b1;
                        rsp_readdata_d   = '0;
                        rsp_error_d      = 1'b1;
                        state_d          = ST_RESP;
                    end
                end
            end

            ST_RD_WAIT: begin
                if (lat_cnt_q == LAT) begin
                    rsp_valid_d    = 1'b1;
                    rsp_readdata_d = avm_readdata;
                    rsp_error_d    = 1'b0;
                    state_d        = ST_RESP;
                end else begin
                    lat_cnt_d = lat_cnt_q + 2'd1;
                end
            end

            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            is_write_q       <= 1'b0;
            lat_cnt_q        <= 2'd0;
            avm_address_q    <= '0;
            avm_chipselect_q <= AVM_CS_IDLE;
            avm_write_n_q    <= AVM_STROBE_IDLE;
            avm_read_n_q     <= AVM_STROBE_IDLE;
            avm_writedata_q  <= '0;
            rsp_valid_q      <= 1'b0;
            rsp_readdata_q   <= '0;
            rsp_error_q      <= 1'b0;
        end else begin
            state_q          <= state_d;
            is_write_q       <= is_write_d;
            lat_cnt_q        <= lat_cnt_d;
            avm_address_q    <= avm_address_d;
            avm_chipselect_q <= avm_chipselect_d;
            avm_write_n_q    <= avm_write_n_d;
            avm_read_n_q     <= avm_read_n_d;
            avm_writedata_q  <= avm_writedata_d;
            rsp_valid_q      <= rsp_valid_d;
            rsp_readdata_q   <= rsp_readdata_d;
            rsp_error_q      <= rsp_error_d;
        end
    end

    assign avm_address    = avm_address_q;
    assign avm_chipselect = avm_chipselect_q;
    assign avm_write_n    = avm_write_n_q;
    assign avm_read_n     = avm_read_n_q;
    assign avm_writedata  = avm_writedata_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_readdata   = rsp_readdata_q;
    assign rsp_error      = rsp_error_q;

endmodule

// File: tb/tb_em_project_final_pd_avmm_cmd_master.sv
// Bench for the Avalon-MM command master: instance A (no read latency, short
// timeout) and instance B (two-cycle read latency, timeout disabled).
module tb_em_project_final_pd_avmm_cmd_master;

    localparam int A_TIMEOUT = 4;
    localparam int B_LAT     = 2;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;

    logic        cmd_valid, cmd_ready, cmd_write;
    logic [1:0]  cmd_address;
    logic [31:0] cmd_writedata;
    logic        rsp_valid, rsp_ready, rsp_error;
    logic [31:0] rsp_readdata;
    logic [1:0]  avm_address;
    logic        avm_chipselect, avm_write_n, avm_read_n, avm_waitrequest;
    logic [31:0] avm_writedata, avm_readdata;

    logic        cmd_valid_b, cmd_ready_b, cmd_write_b;
    logic [1:0]  cmd_address_b;
    logic [31:0] cmd_writedata_b;
    logic        rsp_valid_b, rsp_ready_b, rsp_error_b;
    logic [31:0] rsp_readdata_b;
    logic [1:0]  avm_address_b;
    logic        avm_chipselect_b, avm_write_n_b, avm_read_n_b, avm_waitrequest_b;
    logic [31:0] avm_writedata_b, avm_readdata_b;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          lat;
    } rsp_t;

    rsp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   hs_cyc   = 0;

    em_project_final_pd_avmm_cmd_master #(
        .ADDR_W(2), .DATA_W(32), .READ_LATENCY(0), .TIMEOUT(A_TIMEOUT)
    ) dut_a (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_address(cmd_address), .cmd_writedata(cmd_writedata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_readdata(rsp_readdata), .rsp_error(rsp_error),
        .avm_address(avm_address), .avm_chipselect(avm_chipselect),
        .avm_write_n(avm_write_n), .avm_read_n(avm_read_n),
        .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
        .avm_waitrequest(avm_waitrequest)
    );

    em_project_final_pd_avmm_cmd_master #(
        .ADDR_W(2), .DATA_W(32), .READ_LATENCY(B_LAT), .TIMEOUT(0)
    ) dut_b (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b), .cmd_write(cmd_write_b),
        .cmd_address(cmd_address_b), .cmd_writedata(cmd_writedata_b),
        .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b),
        .rsp_readdata(rsp_readdata_b), .rsp_error(rsp_error_b),
        .avm_address(avm_address_b), .avm_chipselect(avm_chipselect_b),
        .avm_write_n(avm_write_n_b), .avm_read_n(avm_read_n_b),
        .avm_writedata(avm_writedata_b), .avm_readdata(avm_readdata_b),
        .avm_waitrequest(avm_waitrequest_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Handshake one command on instance A (called at a falling edge) and play the slave's stall.
    task automatic applyStimulus(input logic wr, input logic [1:0] addr, input logic [31:0] wdata,
                                 input int stall, input logic stuck, input logic [31:0] rdata,
                                 input int exp_lat);
        rsp_t e;
        checkOutput("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        cmd_valid       = 1'b1;
        cmd_write       = wr;
        cmd_address     = addr;
        cmd_writedata   = wdata;
        avm_waitrequest = stuck || (stall > 0);
        avm_readdata    = (stall == 0 && !stuck) ? rdata : 32'hBAD0_0BAD;
        e.data = (wr || stuck) ? 32'h0 : rdata;
        e.err  = stuck;
        e.lat  = exp_lat;
        exp_q.push_back(e);
        hs_cyc = cyc;
        @(negedge clk);
        cmd_valid     = 1'b0;
        cmd_write     = ~wr;
        cmd_address   = ~addr;
        cmd_writedata = $urandom;
        checkOutput("avm_cs", 32'(avm_chipselect), 32'd1);
        checkOutput("avm_write_n", 32'(avm_write_n), 32'(!wr));
        checkOutput("avm_read_n", 32'(avm_read_n), 32'(wr));
        checkOutput("avm_address", 32'(avm_address), 32'(addr));
        if (wr) checkOutput("avm_writedata", avm_writedata, wdata);
        for (int i = 1; i <= stall; i++) begin
            @(negedge clk);
            checkOutput("avm_cs_stall", 32'(avm_chipselect), 32'd1);
            avm_waitrequest = stuck || (i < stall);
            if (!avm_waitrequest) avm_readdata = rdata;
        end
    endtask

    // Wait for instance A's response, compare it with the scoreboard, optionally hold it off.
    task automatic collectResponse(input int hold);
        rsp_t        e;
        int          waited;
        logic [31:0] held;
        waited = 0;
        while (!rsp_valid && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("rsp_valid_seen", 32'(rsp_valid), 32'd1);
        checkOutput("sb_depth", 32'(exp_q.size()), 32'd1);
        if (rsp_valid && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            avm_readdata    = 32'hBAD0_0BAD;
            avm_waitrequest = 1'b0;
            checkOutput("rsp_readdata", rsp_readdata, e.data);
            checkOutput("rsp_error", 32'(rsp_error), 32'(e.err));
            checkOutput("rsp_latency", 32'(cyc - hs_cyc), 32'(e.lat));
            checkOutput("avm_cs_idle", 32'(avm_chipselect), 32'd0);
            checkOutput("avm_write_n_idle", 32'(avm_write_n), 32'd1);
            checkOutput("avm_read_n_idle", 32'(avm_read_n), 32'd1);
            held = rsp_readdata;
            for (int h = 0; h < hold; h++) begin
                cmd_valid     = 1'b1;
                cmd_write     = 1'b1;
                cmd_address   = 2'd3;
                cmd_writedata = $urandom;
                @(negedge clk);
                checkOutput("hold_rsp_valid", 32'(rsp_valid), 32'd1);
                checkOutput("hold_rsp_readdata", rsp_readdata, held);
                checkOutput("hold_rsp_error", 32'(rsp_error), 32'(e.err));
                checkOutput("hold_cmd_ready", 32'(cmd_ready), 32'd0);
                checkOutput("hold_avm_cs", 32'(avm_chipselect), 32'd0);
            end
            rsp_ready = 1'b1;
            @(negedge clk);
            cmd_valid = 1'b0;
            checkOutput("rsp_valid_drop", 32'(rsp_valid), 32'd0);
            checkOutput("cmd_ready_after", 32'(cmd_ready), 32'd1);
        end
    endtask

    initial begin
        rsp_t e;
        logic saw_rsp;
        logic cs_low;
        int   waited;

        reset = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_address = 2'd0; cmd_writedata = 32'h0;
        rsp_ready = 1'b1; avm_readdata = 32'h0; avm_waitrequest = 1'b0;
        cmd_valid_b = 1'b0; cmd_write_b = 1'b0; cmd_address_b = 2'd0; cmd_writedata_b = 32'h0;
        rsp_ready_b = 1'b1; avm_readdata_b = 32'h0; avm_waitrequest_b = 1'b0;

        repeat (2) @(negedge clk);
        checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        checkOutput("rst_cs", 32'(avm_chipselect), 32'd0);
        checkOutput("rst_write_n", 32'(avm_write_n), 32'd1);
        checkOutput("rst_read_n", 32'(avm_read_n), 32'd1);
        checkOutput("rst_address", 32'(avm_address), 32'd0);
        checkOutput("rst_writedata", avm_writedata, 32'd0);
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst_rsp_readdata", rsp_readdata, 32'd0);
        checkOutput("rst_rsp_error", 32'(rsp_error), 32'd0);
        checkOutput("rst_b_cs", 32'(avm_chipselect_b), 32'd0);
        checkOutput("rst_b_cmd_ready", 32'(cmd_ready_b), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        $display("[TB] reset released");

        applyStimulus(1'b1, 2'd0, 32'h3FF, 0, 1'b0, 32'h0, 2);
        collectResponse(0);
        applyStimulus(1'b0, 2'd0, 32'h0, 0, 1'b0, 32'h155, 2);
        collectResponse(0);
        applyStimulus(1'b0, 2'd2, 32'h0, 2, 1'b0, 32'h1234_5678, 4);
        collectResponse(0);
        applyStimulus(1'b1, 2'd3, 32'hDEAD_0042, 1, 1'b0, 32'h0, 3);
        collectResponse(0);

        $display("[TB] timeout and last-stall-edge accept");
        applyStimulus(1'b0, 2'd1, 32'h0, A_TIMEOUT - 1, 1'b1, 32'h777, A_TIMEOUT + 1);
        collectResponse(0);
        applyStimulus(1'b0, 2'd1, 32'h0, A_TIMEOUT - 1, 1'b0, 32'hCAFE, A_TIMEOUT + 1);
        collectResponse(0);

        $display("[TB] response backpressure");
        rsp_ready = 1'b0;
        applyStimulus(1'b1, 2'd2, 32'hAAAA_5555, 0, 1'b0, 32'h0, 2);
        collectResponse(5);
        applyStimulus(1'b0, 2'd1, 32'h0, 0, 1'b0, 32'h99, 2);
        collectResponse(0);

        $display("[TB] reset during ISSUE");
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_address = 2'd3; avm_waitrequest = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        checkOutput("r6_cs_before", 32'(avm_chipselect), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("r6_cs", 32'(avm_chipselect), 32'd0);
        checkOutput("r6_write_n", 32'(avm_write_n), 32'd1);
        checkOutput("r6_read_n", 32'(avm_read_n), 32'd1);
        checkOutput("r6_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("r6_cmd_ready_in_reset", 32'(cmd_ready), 32'd0);
        reset = 1'b0;
        avm_waitrequest = 1'b0;
        @(negedge clk);
        checkOutput("r6_cmd_ready", 32'(cmd_ready), 32'd1);
        saw_rsp = 1'b0;
        for (int i = 0; i < 4; i++) begin
            saw_rsp = saw_rsp | rsp_valid;
            @(negedge clk);
        end
        checkOutput("r6_no_rsp", 32'(saw_rsp), 32'd0);
        applyStimulus(1'b1, 2'd1, 32'h5A5A_A5A5, 0, 1'b0, 32'h0, 2);
        collectResponse(0);

        $display("[TB] instance B read latency");
        cmd_valid_b = 1'b1; cmd_write_b = 1'b0; cmd_address_b = 2'd3;
        avm_waitrequest_b = 1'b1; avm_readdata_b = 32'hBAD0_0BAD;
        e.data = 32'hA5; e.err = 1'b0; e.lat = 2 + 3 + B_LAT;
        exp_q.push_back(e);
        hs_cyc = cyc;
        @(negedge clk);
        cmd_valid_b = 1'b0;
        checkOutput("b_cs", 32'(avm_chipselect_b), 32'd1);
        checkOutput("b_read_n", 32'(avm_read_n_b), 32'd0);
        checkOutput("b_address", 32'(avm_address_b), 32'd3);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            checkOutput("b_cs_stall", 32'(avm_chipselect_b), 32'd1);
            avm_waitrequest_b = (i < 3);
        end
        @(negedge clk);
        checkOutput("b_cs_drop", 32'(avm_chipselect_b), 32'd0);
        @(negedge clk);
        checkOutput("b_rsp_not_early", 32'(rsp_valid_b), 32'd0);
        avm_readdata_b = 32'hA5;
        @(negedge clk);
        avm_readdata_b = 32'hBAD0_0BAD;
        checkOutput("b_sb_depth", 32'(exp_q.size()), 32'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput("b_rsp_valid", 32'(rsp_valid_b), 32'd1);
            checkOutput("b_rsp_readdata", rsp_readdata_b, e.data);
            checkOutput("b_rsp_error", 32'(rsp_error_b), 32'(e.err));
            checkOutput("b_rsp_latency", 32'(cyc - hs_cyc), 32'(e.lat));
        end
        @(negedge clk);
        checkOutput("b_rsp_drop", 32'(rsp_valid_b), 32'd0);

        $display("[TB] instance B timeout disabled");
        cmd_valid_b = 1'b1; cmd_write_b = 1'b0; cmd_address_b = 2'd1; avm_waitrequest_b = 1'b1;
        @(negedge clk);
        cmd_valid_b = 1'b0;
        saw_rsp = 1'b0;
        cs_low  = 1'b0;
        for (int i = 0; i < 300; i++) begin
            saw_rsp = saw_rsp | rsp_valid_b;
            cs_low  = cs_low | !avm_chipselect_b;
            @(negedge clk);
        end
        checkOutput("b_to0_no_rsp", 32'(saw_rsp), 32'd0);
        checkOutput("b_to0_cs_held", 32'(cs_low), 32'd0);
        avm_waitrequest_b = 1'b0;
        avm_readdata_b    = 32'h42;
        waited = 0;
        while (!rsp_valid_b && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("b_to0_rsp_valid", 32'(rsp_valid_b), 32'd1);
        checkOutput("b_to0_readdata", rsp_readdata_b, 32'h42);
        checkOutput("b_to0_error", 32'(rsp_error_b), 32'd0);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
